dmem_wait_responder: RTL and testbench

Responder side of the pipeline's MEM-stage data-memory interface (MemoryRead/MemoryWrite/Address/WriteData/ReadData). It serves each access from an internal word array after a configurable number of wait states. While an access is in flight it drops Ready, and the hazard unit uses that to freeze the pipeline. It replaces the zero-latency data memory for slow-memory and stall-path testing.

---
 rtl/dmem_wait_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_wait_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// MEM-stage data-memory responder: serves loads/stores from a local word array
// and holds Ready low for WAIT_CYCLES cycles per access so the pipeline stalls.
module dmem_wait_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              MemoryRead,
  input  logic              MemoryWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              ProtoErr,
  output logic [CNT_W-1:0]  ReadCount,
  output logic [CNT_W-1:0]  WriteCount
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              both_req;

  // A simultaneous read and write is served as a write; the read is dropped.
  assign both_req = MemoryRead & MemoryWrite;

  always_ff @(negedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  if (WAIT_CYCLES == 0) begin : g_zero
    logic              rd_only;
    logic [DATA_W-1:0] rdata_p1;

    assign rd_only   = MemoryRead & ~MemoryWrite;
    assign Ready     = 1'b1;
    assign mem_we    = Reset_L & MemoryWrite;
    assign mem_waddr = Address;
    assign mem_wdata = WriteData;
    assign ReadData  = rd_only ? mem[Address] : rdata_p1;

    // Stage p1: last completed read is held once the request drops.
    always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
        rdata_p1   <= '0;
        ProtoErr   <= 1'b0;
        ReadCount  <= '0;
        WriteCount <= '0;
      end else begin
        ProtoErr <= both_req;
        if (rd_only) begin
          rdata_p1  <= mem[Address];
          ReadCount <= ReadCount + CNT_W'(1);
        end
        if (MemoryWrite) WriteCount <= WriteCount + CNT_W'(1);
      end
    end
  end else begin : g_wait
    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              write_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic              req;
    logic              accept;
    logic              finish;
    logic              op_write;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    assign req    = MemoryRead | MemoryWrite;
    assign accept = (state == S_IDLE) & req;
    assign finish = (accept & (WAIT_CYCLES == 1)) | ((state == S_WAIT) & (cnt == '0));

    // In IDLE the operation comes straight from the ports, afterwards from the latch.
    assign op_write  = (state == S_IDLE) ? MemoryWrite : write_p1;
    assign op_addr   = (state == S_IDLE) ? Address     : addr_p1;
    assign op_wdata  = (state == S_IDLE) ? WriteData   : wdata_p1;
    assign Ready     = (state == S_DONE) | ((state == S_IDLE) & ~req);
    assign mem_we    = Reset_L & finish & op_write;
    assign mem_waddr = op_addr;
    assign mem_wdata = op_wdata;

    // Stage p1: request latch, wait counter and completion side effects.
    always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
        state      <= S_IDLE;
        cnt        <= '0;
        write_p1   <= 1'b0;
        addr_p1    <= '0;
        wdata_p1   <= '0;
        ReadData   <= '0;
        ProtoErr   <= 1'b0;
        ReadCount  <= '0;
        WriteCount <= '0;
      end else begin
        ProtoErr <= accept & both_req;
        case (state)
          S_IDLE: begin
            if (req) begin
              write_p1 <= MemoryWrite;
              addr_p1  <= Address;
              wdata_p1 <= WriteData;
              if (WAIT_CYCLES == 1) begin
                state <= S_DONE;
              end else begin
                state <= S_WAIT;
                cnt   <= CNT_INIT;
              end
            end
          end
          S_WAIT: begin
            if (cnt == '0) state <= S_DONE;
            else           cnt   <= cnt - CW'(1);
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
        if (finish) begin
          if (op_write) begin
            WriteCount <= WriteCount + CNT_W'(1);
          end else begin
            ReadData  <= mem[op_addr];
            ReadCount <= ReadCount + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: a 2-wait-state instance and a zero-latency
// instance, each compared against a transaction-level memory model.
module tb_dmem_wait_responder;

  logic        CLK;
  logic        a_rst, a_rd, a_wr;
  logic [5:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        a_ready, a_perr;
  logic [15:0] a_rc, a_wc;

  logic        b_rst, b_rd, b_wr;
  logic [5:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        b_ready, b_perr;
  logic [1:0]  b_rc, b_wc;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ma [64];
  logic [31:0] mb [64];
  logic [31:0] exp_rd_a;
  logic [15:0] rc_a, wc_a;
  logic [31:0] hold_b;
  logic [1:0]  rc_b, wc_b;
  bit          pe_b;

  dmem_wait_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(2), .CNT_W(16)) dut_a (
    .CLK(CLK), .Reset_L(a_rst), .MemoryRead(a_rd), .MemoryWrite(a_wr),
    .Address(a_addr), .WriteData(a_wdata), .ReadData(a_rdata), .Ready(a_ready),
    .ProtoErr(a_perr), .ReadCount(a_rc), .WriteCount(a_wc)
  );

  dmem_wait_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(0), .CNT_W(2)) dut_b (
    .CLK(CLK), .Reset_L(b_rst), .MemoryRead(b_rd), .MemoryWrite(b_wr),
    .Address(b_addr), .WriteData(b_wdata), .ReadData(b_rdata), .Ready(b_ready),
    .ProtoErr(b_perr), .ReadCount(b_rc), .WriteCount(b_wc)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on the 2-wait instance; scr=1 scrambles inputs while busy,
  // scr=2 switches to a write of address 9 while busy.
  task automatic do_access(input bit rd, input bit wr, input logic [5:0] a,
                           input logic [31:0] d, input int scr);
    int lows;
    bit done;
    lows = 0;
    done = 1'b0;
    a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge CLK);
      check("a_perr", a_perr, (i == 1) && rd && wr);
      if (a_ready) begin
        done = 1'b1;
        if (wr) begin
          ma[a] = d;
          wc_a++;
        end else begin
          exp_rd_a = ma[a];
          rc_a++;
        end
        check("a_stall_cycles", lows, 2);
        check("a_rdata", a_rdata, exp_rd_a);
        check("a_rc", a_rc, rc_a);
        check("a_wc", a_wc, wc_a);
      end else begin
        lows++;
      end
      @(negedge CLK); #1;
      if (!done && scr == 1) begin
        a_rd    = 1'($urandom_range(0, 1));
        a_wr    = 1'($urandom_range(0, 1));
        a_addr  = 6'($urandom_range(0, 63));
        a_wdata = $urandom;
      end else if (!done && scr == 2) begin
        a_rd = 1'b0; a_wr = 1'b1; a_addr = 6'd9; a_wdata = 32'hA5A5_0009;
      end
    end
    check("a_done", done, 1'b1);
  endtask

  task automatic idle_a(input int n);
    a_rd = 1'b0; a_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      check("a_idle_ready", a_ready, 1'b1);
      check("a_idle_rdata", a_rdata, exp_rd_a);
      check("a_idle_perr", a_perr, 1'b0);
      @(negedge CLK); #1;
    end
  endtask

  initial begin
    a_rst = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    exp_rd_a = '0; rc_a = '0; wc_a = '0;
    hold_b = '0; rc_b = '0; wc_b = '0; pe_b = 1'b0;

    repeat (2) @(posedge CLK);
    check("a_rst_ready", a_ready, 1'b1);
    check("a_rst_rdata", a_rdata, 32'h0);
    check("a_rst_rc", a_rc, 16'h0);
    check("a_rst_wc", a_wc, 16'h0);
    check("a_rst_perr", a_perr, 1'b0);
    check("b_rst_ready", b_ready, 1'b1);
    check("b_rst_rdata", b_rdata, 32'h0);
    check("b_rst_rc", b_rc, 2'h0);
    check("b_rst_perr", b_perr, 1'b0);
    @(negedge CLK); #1;
    a_rst = 1'b1; b_rst = 1'b1;

    // 2-wait instance: directed accesses
    do_access(1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF, 0);
    do_access(1'b1, 1'b0, 6'd5, 32'h0, 0);
    do_access(1'b1, 1'b0, 6'd5, 32'h0, 2);
    do_access(1'b0, 1'b1, 6'd9, 32'hA5A5_0009, 0);
    do_access(1'b1, 1'b0, 6'd5, 32'h0, 0);
    do_access(1'b1, 1'b1, 6'd3, 32'h1234_5678, 0);
    do_access(1'b1, 1'b0, 6'd3, 32'h0, 0);
    do_access(1'b1, 1'b0, 6'd9, 32'h0, 0);
    do_access(1'b0, 1'b1, 6'd7, 32'h0000_1111, 0);
    idle_a(2);

    // reset in the middle of a write's wait state
    a_wr = 1'b1; a_addr = 6'd7; a_wdata = 32'h55;
    @(posedge CLK);
    check("a_accept_ready", a_ready, 1'b0);
    @(negedge CLK); #1;
    @(posedge CLK); #1;
    a_rst = 1'b0; a_wr = 1'b0;
    #2;
    check("a_inrst_ready", a_ready, 1'b1);
    a_rst = 1'b1;
    rc_a = '0; wc_a = '0; exp_rd_a = '0;
    @(negedge CLK); #1;
    @(posedge CLK);
    check("a_abort_ready", a_ready, 1'b1);
    check("a_abort_wc", a_wc, wc_a);
    check("a_abort_rc", a_rc, rc_a);
    check("a_abort_rdata", a_rdata, exp_rd_a);
    @(negedge CLK); #1;
    do_access(1'b1, 1'b0, 6'd7, 32'h0, 0);

    // 2-wait instance: randomized accesses
    for (int i = 0; i < 64; i++) do_access(1'b0, 1'b1, 6'(i), $urandom, 1);
    for (int i = 0; i < 80; i++) begin
      int op;
      int gap;
      op  = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 2));
      do_access(op != 1, op != 0, 6'($urandom_range(0, 63)), $urandom,
                int'($urandom_range(0, 1)));
      if (gap > 0) idle_a(gap);
    end
    idle_a(1);

    // zero-latency instance: five reads of address 0
    b_wr = 1'b1; b_addr = 6'd0; b_wdata = 32'hCAFE_0001;
    @(posedge CLK);
    check("b_wr_ready", b_ready, 1'b1);
    @(negedge CLK); #1;
    mb[0] = 32'hCAFE_0001; wc_b++;
    b_wr = 1'b0; b_rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      check("b_rd_ready", b_ready, 1'b1);
      check("b_rd_data", b_rdata, mb[0]);
      @(negedge CLK); #1;
      rc_b++;
      check("b_rd_count", b_rc, rc_b);
    end
    hold_b = mb[0];
    b_rd = 1'b0; b_addr = 6'd5;
    @(posedge CLK);
    check("b_hold_rdata", b_rdata, hold_b);
    check("b_wc", b_wc, wc_b);
    @(negedge CLK); #1;

    // zero-latency instance: randomized cycles
    for (int i = 0; i < 160; i++) begin
      bit          rd, wr;
      logic [5:0]  a;
      logic [31:0] d;
      if (i < 64) begin
        rd = 1'b0; wr = 1'b1; a = 6'(i);
      end else begin
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        a  = 6'($urandom_range(0, 63));
      end
      d = $urandom;
      b_rd = rd; b_wr = wr; b_addr = a; b_wdata = d;
      @(posedge CLK);
      check("b_ready", b_ready, 1'b1);
      check("b_rdata", b_rdata, (rd && !wr) ? mb[a] : hold_b);
      check("b_perr", b_perr, pe_b);
      check("b_rc", b_rc, rc_b);
      check("b_wc", b_wc, wc_b);
      @(negedge CLK); #1;
      if (rd && !wr) begin
        hold_b = mb[a];
        rc_b++;
      end
      if (wr) begin
        mb[a] = d;
        wc_b++;
      end
      pe_b = rd && wr;
    end
    b_rd = 1'b0; b_wr = 1'b0;
    @(posedge CLK);
    check("b_final_rc", b_rc, rc_b);
    check("b_final_wc", b_wc, wc_b);
    check("b_final_perr", b_perr, pe_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
